// File: rtl/pc_gen.sv
// Fetch program-counter generator for the RV64I front end. It provides a
// BOOT/RUN/HALT control FSM, prioritised trap/redirect handling, and cycle/instret counters.
module pc_gen #(
  parameter int unsigned           XLEN      = 64,
  parameter logic [XLEN-1:0]       RESET_VEC = 'h8000_0000,
  parameter int unsigned           CNT_W     = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             fetch_valid_o,
  input  logic             fetch_ready_i,
  output logic [XLEN-1:0]  pc_o,
  input  logic             redirect_valid_i,
  input  logic [XLEN-1:0]  redirect_target_i,
  input  logic             trap_valid_i,
  input  logic [XLEN-1:0]  trap_vector_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             retire_i,
  output logic             misalign_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [CNT_W-1:0] cycle_q, instret_q;

  logic            fetch_fire;
  logic            target_aligned;
  logic [XLEN-1:0] trap_pc;

  assign fetch_fire     = (state_q == RUN) && fetch_ready_i;
  assign target_aligned = (redirect_target_i[1:0] == 2'b00);
  assign trap_pc        = trap_vector_i & ~XLEN'(3);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;

    unique case (state_q)
      BOOT: state_d = RUN;  // requests are deliberately ignored for the boot edge
      RUN, HALT: begin
        if (trap_valid_i) begin
          pc_d       = trap_pc;
          state_d    = RUN;
          misalign_d = 1'b0;
        end else if (state_q == RUN && redirect_valid_i) begin
          if (target_aligned) begin
            pc_d = redirect_target_i;
          end else begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end
        end else if (state_q == RUN && halt_i) begin
          // An accepted fetch this cycle does not advance pc when halting.
          state_d = HALT;
        end else if (fetch_fire) begin
          pc_d = pc_q + XLEN'(4);
        end else if (state_q == HALT && resume_i && !misalign_q) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Counters run independently of the FSM and wrap freely.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire_i) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign fetch_valid_o = (state_q == RUN);
  assign pc_o          = pc_q;
  assign misalign_o    = misalign_q;
  assign state_o       = state_q;
  assign cycle_o       = cycle_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios and a randomized phase,
// all compared against a behavioural model of the fetch PC rules.
module tb_pc_gen;

  localparam logic [63:0] RST_VEC = 64'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_ready_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_target_i = '0;
  logic        trap_valid_i = 1'b0;
  logic [63:0] trap_vector_i = '0;
  logic        halt_i = 1'b0;
  logic        resume_i = 1'b0;
  logic        retire_i = 1'b0;

  logic        fetch_valid_o, misalign_o;
  logic [63:0] pc_o, cycle_o, instret_o;
  logic [1:0]  state_o;

  logic        s_fetch_valid, s_misalign;
  logic [63:0] s_pc;
  logic [1:0]  s_state;
  logic [3:0]  s_cycle, s_instret;

  pc_gen u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i), .pc_o(pc_o),
    .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
    .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
    .halt_i(halt_i), .resume_i(resume_i), .retire_i(retire_i),
    .misalign_o(misalign_o), .state_o(state_o),
    .cycle_o(cycle_o), .instret_o(instret_o)
  );

  pc_gen #(.CNT_W(4)) u_small (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fetch_valid_o(s_fetch_valid), .fetch_ready_i(fetch_ready_i), .pc_o(s_pc),
    .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
    .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
    .halt_i(halt_i), .resume_i(resume_i), .retire_i(retire_i),
    .misalign_o(s_misalign), .state_o(s_state),
    .cycle_o(s_cycle), .instret_o(s_instret)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state: mode is 0 BOOT, 1 RUN, 2 HALT.
  int          m_mode;
  logic [63:0] m_pc;
  bit          m_mis;
  longint unsigned m_cycle, m_instret;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_pc = RST_VEC; m_mis = 0; m_cycle = 0; m_instret = 0;
  endfunction

  function automatic void model_edge();
    bit running = (m_mode == 1);
    m_cycle++;
    if (retire_i) m_instret++;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (trap_valid_i) begin
      m_pc = trap_vector_i - (trap_vector_i % 4);
      m_mode = 1; m_mis = 0;
    end else if (running && redirect_valid_i) begin
      if (redirect_target_i % 4 == 0) m_pc = redirect_target_i;
      else begin m_mis = 1; m_mode = 2; end
    end else if (running && halt_i) begin
      m_mode = 2;
    end else if (running && fetch_ready_i) begin
      m_pc = m_pc + 64'd4;
    end else if (m_mode == 2 && resume_i && !m_mis) begin
      m_mode = 1;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".pc"},      pc_o, m_pc);
    check({tag, ".valid"},   64'(fetch_valid_o), 64'(m_mode == 1));
    check({tag, ".state"},   64'(state_o), 64'(m_mode));
    check({tag, ".mis"},     64'(misalign_o), 64'(m_mis));
    check({tag, ".cycle"},   cycle_o, m_cycle);
    check({tag, ".instret"}, instret_o, m_instret);
    check({tag, ".s_pc"},    s_pc, m_pc);
    check({tag, ".s_cyc"},   64'(s_cycle), m_cycle % 16);
    check({tag, ".s_inst"},  64'(s_instret), m_instret % 16);
  endtask

  task automatic clear_req();
    redirect_valid_i = 0; trap_valid_i = 0; halt_i = 0; resume_i = 0;
  endtask

  // One clock edge: model follows the inputs present at the edge, outputs checked 1ns later.
  task automatic step(input string tag);
    @(posedge clk_i);
    if (rst_ni) model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [3:0] prev_inst;
    model_reset();
    fetch_ready_i = 1;
    #12;
    compare_all("rst");
    check("rst.pc_const", pc_o, 64'h8000_0000);

    // Reset release: boot edge, then sequential advance.
    @(posedge clk_i); #1; rst_ni = 1;
    step("boot");
    check("boot.pc", pc_o, 64'h8000_0000);
    check("boot.cyc", cycle_o, 64'd1);
    step("adv1");
    check("adv1.pc", pc_o, 64'h8000_0004);

    // Ready low: pc holds, cycle counts on.
    fetch_ready_i = 0;
    repeat (3) step("stall");
    check("stall.pc", pc_o, 64'h8000_0004);
    check("stall.cyc", cycle_o, 64'd5);
    fetch_ready_i = 1;
    step("adv2");
    check("adv2.pc", pc_o, 64'h8000_0008);

    // Trap beats redirect; low vector bits forced to zero.
    trap_valid_i = 1; trap_vector_i = 64'h8000_1003;
    redirect_valid_i = 1; redirect_target_i = 64'h8000_2000;
    step("trap_vs_redir");
    check("trap_vs_redir.pc", pc_o, 64'h8000_1000);
    clear_req();

    // Misaligned redirect halts sticky; resume ignored; trap recovers.
    redirect_valid_i = 1; redirect_target_i = 64'h8000_0102;
    step("misalign");
    check("misalign.state", 64'(state_o), 64'd2);
    check("misalign.flag", 64'(misalign_o), 64'd1);
    clear_req(); resume_i = 1;
    step("mis_resume");
    check("mis_resume.state", 64'(state_o), 64'd2);
    clear_req(); trap_valid_i = 1; trap_vector_i = 64'h8000_0200;
    step("mis_trap");
    check("mis_trap.pc", pc_o, 64'h8000_0200);
    check("mis_trap.flag", 64'(misalign_o), 64'd0);
    clear_req();

    // Halt with a completing handshake: pc holds.
    halt_i = 1;
    step("halt");
    check("halt.pc", pc_o, 64'h8000_0200);
    clear_req(); resume_i = 1;
    step("resume");
    clear_req();
    step("post_resume");
    check("post_resume.pc", pc_o, 64'h8000_0204);

    // PC wrap at the top of the address space.
    trap_valid_i = 1; trap_vector_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step("top");
    check("top.pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    clear_req();
    step("wrap");
    check("wrap.pc", pc_o, 64'h0);

    // Narrow instret wraps 15 -> 0 with retire held.
    retire_i = 1;
    for (int i = 0; i < 20; i++) begin
      prev_inst = s_instret;
      step("retire");
      if (prev_inst == 4'hF) check("inst_wrap", 64'(s_instret), 64'd0);
    end
    retire_i = 0;

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      fetch_ready_i    = ($urandom_range(99) < 70);
      retire_i         = $urandom_range(1);
      trap_valid_i     = ($urandom_range(99) < 5);
      trap_vector_i    = {$urandom, $urandom};
      redirect_valid_i = ($urandom_range(99) < 10);
      redirect_target_i = {$urandom, $urandom} & (($urandom_range(3) == 0) ? ~64'h0 : ~64'h3);
      halt_i           = ($urandom_range(99) < 5);
      resume_i         = ($urandom_range(99) < 25);
      step("rand");
    end
    clear_req();

    // Asynchronous reset mid-cycle.
    #2; rst_ni = 0; #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst.cyc", cycle_o, 64'd0);
    #10; rst_ni = 1;
    step("reboot");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV64I fetch front end. It holds the architectural fetch PC and presents it to instruction fetch through a valid/ready handshake. It advances the PC sequentially on each accepted fetch and applies prioritised redirects (trap over branch/jump). It also detects misaligned redirect targets, supports halt/resume, and maintains free-running cycle and retired-instruction counters.

## Interface
- XLEN, 64: PC and address width.
- RESET_VEC, 64'h8000_0000: PC value loaded on reset. Must be 4-byte aligned.
- CNT_W, 64: width of the cycle and instret counters.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- fetch_valid_o  out  1  pc_o is a valid fetch request.
- fetch_ready_i  in  1  fetch stage accepts pc_o this cycle.
- pc_o  out  XLEN  current fetch PC, registered.
- redirect_valid_i  in  1  branch/jump redirect request.
- redirect_target_i  in  XLEN  redirect destination.
- trap_valid_i  in  1  trap/exception redirect request.
- trap_vector_i  in  XLEN  trap destination; bits [1:0] are ignored and forced to 0.
- halt_i  in  1  request to stop issuing fetches.
- resume_i  in  1  request to leave HALT.
- retire_i  in  1  one instruction retired this cycle.
- misalign_o  out  1  sticky flag: a misaligned redirect was rejected.
- state_o  out  2  FSM state: 0 BOOT, 1 RUN, 2 HALT.
- cycle_o  out  CNT_W  cycles since reset release.
- instret_o  out  CNT_W  retired-instruction count.

## Operation
- FSM states: BOOT, RUN, HALT. On reset the FSM enters BOOT.
- BOOT lasts exactly one clock edge and then moves to RUN. In BOOT all request inputs (trap, redirect, halt, resume) are ignored.
- fetch_valid_o = (state == RUN). It is decoded from registered state only and never depends on fetch_ready_i or on any other input.
- Per-edge priority, highest first; only the first matching action is taken:
  1. Trap: trap_valid_i in RUN or HALT.
     - pc <= {trap_vector_i[XLEN-1:2], 2'b00}.
     - state <= RUN; misalign_o <= 0.
  2. Aligned redirect: redirect_valid_i in RUN with redirect_target_i[1:0] == 0.
     - pc <= redirect_target_i.
  3. Misaligned redirect: redirect_valid_i in RUN with redirect_target_i[1:0] != 0.
     - pc unchanged; misalign_o <= 1; state <= HALT.
  4. Halt: halt_i in RUN.
     - state <= HALT; pc unchanged. This applies even if a fetch handshake completes the same cycle: the handshake still counts as accepted, but pc does not advance.
  5. Advance: fetch_valid_o && fetch_ready_i.
     - pc <= pc + 4, modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  6. Resume: resume_i in HALT with misalign_o == 0.
     - state <= RUN.
     - resume_i while misalign_o == 1 is ignored; only a trap leaves that HALT.
- redirect_valid_i and halt_i in HALT are ignored.
- Counters are independent of the FSM:
  - cycle_o increments every edge with rst_ni high, including BOOT and HALT.
  - instret_o increments on every edge where retire_i = 1.
  - Both wrap modulo 2^CNT_W with no saturation.

## Timing
- Reset values (asynchronous, visible while rst_ni = 0):
  - pc_o = RESET_VEC
  - fetch_valid_o = 0
  - state_o = BOOT
  - misalign_o = 0
  - cycle_o = 0
  - instret_o = 0
- The first edge with rst_ni = 1 moves the FSM to RUN. fetch_valid_o rises after that edge, with pc_o = RESET_VEC and cycle_o = 1.
- Redirect/trap latency is one cycle: a request sampled at edge N is visible on pc_o after edge N. A fetch handshake in that same cycle is accepted for the old pc_o.
- Handshake: while fetch_valid_o = 1 and fetch_ready_i = 0, pc_o holds stable unless a trap or redirect occurs.
- Reset asserted mid-operation forces all reset values immediately. Pending requests are discarded and counters clear.
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.

## Test plan
- Reset release, fetch_ready_i = 1 held → fetch_valid_o rises one edge after release. pc_o sequence is 0x80000000, 0x80000004, 0x80000008; cycle_o = 1, 2, 3.
- fetch_ready_i = 0 for 3 cycles → pc_o holds at 0x80000004; cycle_o still increments.
- Simultaneous trap_valid_i (vector 0x80001003) and redirect_valid_i (target 0x80002000) with ready = 1 → pc_o = 0x80001000 next cycle; no advance.
- Redirect to 0x80000102 → misalign_o = 1, state_o = HALT, fetch_valid_o = 0. resume_i is ignored. A trap to 0x80000200 gives state_o = RUN, misalign_o = 0, pc_o = 0x80000200.
- halt_i with ready = 1 → state_o = HALT and pc_o holds. resume_i returns to RUN; the next accepted fetch advances by 4.
- Edge cases:
  - XLEN = 64, pc = 0xFFFF_FFFF_FFFF_FFFC, ready = 1 → pc_o = 0.
  - CNT_W = 4 with retire_i held high → instret_o wraps 15 → 0.
  - rst_ni pulsed low mid-run → all outputs return to reset values asynchronously.
